updown_mod_counter: RTL and testbench

UPDOWN_MOD_COUNTER -- requirements
Module: updown_mod_counter

---
 rtl/updown_pkg.sv | 9 +
 rtl/updown_mod_counter.sv | 107 ++++++++++
 tb/tb_updown_mod_counter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/updown_pkg.sv
// Shared direction and boundary-behaviour encodings for the up/down modulo counter.
package updown_pkg;

  localparam logic MODE_UP   = 1'b1;
  localparam logic MODE_DOWN = 1'b0;
  localparam logic BND_WRAP  = 1'b0;
  localparam logic BND_SAT   = 1'b1;

endpackage : updown_pkg

// File: rtl/updown_mod_counter.sv
// Programmable-modulus up/down counter with load, wrap/saturate boundary handling,
// a terminal-count strobe and a sticky overflow/underflow flag.
module updown_mod_counter
  import updown_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic             mode,
  input  logic             sat,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] max_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] RST_Q = RST_VAL[WIDTH-1:0];

  logic [WIDTH-1:0] q_q, q_d;
  logic             ovf_q, ovf_d;

  // One set of boundary compares feeds both the next-state mux and tc.
  logic at_top, at_zero, above_max, at_bnd;

  always_comb begin
    at_top    = (q_q >= max_val);
    at_zero   = (q_q == '0);
    above_max = (q_q > max_val);
    at_bnd    = 1'b0;
    case (mode)
      MODE_UP:   at_bnd = at_top;
      MODE_DOWN: at_bnd = at_zero;
      default:   at_bnd = 1'b0;
    endcase
  end

  // Gated by rst so the strobe cannot fire while the count is being held in reset.
  assign tc = rst & en & ~load & at_bnd;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    q_d = q_q;
    if (load) begin
      q_d = (din > max_val) ? max_val : din;
    end else if (en) begin
      case (mode)
        MODE_UP: begin
          if (!at_top) begin
            q_d = q_q + 1'b1;
          end else begin
            case (sat)
              BND_SAT:  q_d = max_val;
              BND_WRAP: q_d = '0;
              default:  q_d = '0;
            endcase
          end
        end
        MODE_DOWN: begin
          if (at_zero) begin
            case (sat)
              BND_SAT:  q_d = '0;
              BND_WRAP: q_d = max_val;
              default:  q_d = '0;
            endcase
          end else if (above_max) begin
            // Limit was lowered under a live count: snap back into range.
            q_d = max_val;
          end else begin
            q_d = q_q - 1'b1;
          end
        end
        default: q_d = q_q;
      endcase
    end
  end

  // Set dominates clear when both land on the same edge.
  always_comb begin
    ovf_d = ovf_q;
    if (tc) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: sequential state uses non-blocking assignments so all flops sample together.
      q_q   <= RST_Q;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      ovf_q <= ovf_d;
    end
  end

  assign q   = q_q;
  assign ovf = ovf_q;

endmodule : updown_mod_counter

// File: tb/tb_updown_mod_counter.sv
// Directed, table-driven bench for updown_mod_counter at WIDTH=4, RST_VAL=0.
module tb_updown_mod_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, load, mode, sat, clr_ovf;
  logic [3:0] din, max_val;
  logic [3:0] q;
  logic       tc, ovf;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  updown_mod_counter #(.WIDTH(4), .RST_VAL(0)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .load    (load),
    .mode    (mode),
    .sat     (sat),
    .din     (din),
    .max_val (max_val),
    .clr_ovf (clr_ovf),
    .q       (q),
    .tc      (tc),
    .ovf     (ovf)
  );

  typedef struct {
    logic       en, load, mode, sat, clr;
    logic [3:0] din, mx;
    logic       exp_tc;
    logic [3:0] exp_q;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic v_en, v_load, v_mode, v_sat, v_clr,
                              input logic [3:0] v_din, v_mx,
                              input logic e_tc, input logic [3:0] e_q, input logic e_ovf);
    vec_t v;
    v.en = v_en; v.load = v_load; v.mode = v_mode; v.sat = v_sat; v.clr = v_clr;
    v.din = v_din; v.mx = v_mx;
    v.exp_tc = e_tc; v.exp_q = e_q; v.exp_ovf = e_ovf;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    // Columns: en load mode sat clr din max | tc(before edge) q(after) ovf(after)
    // Load 3, count up to 9 and wrap with max 9.
    vecs.push_back(mk(0, 1, 1, 0, 0,  3,  9, 0,  3, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0,  0,  9, 0,  4, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0,  0,  9, 0,  5, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0,  0,  9, 0,  6, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0,  0,  9, 0,  7, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0,  0,  9, 0,  8, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0,  0,  9, 0,  9, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0,  0,  9, 1,  0, 1));
    vecs.push_back(mk(1, 0, 1, 0, 0,  0,  9, 0,  1, 1));
    // Load 2 (clearing ovf), count down saturating at 0.
    vecs.push_back(mk(0, 1, 0, 1, 1,  2, 15, 0,  2, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0,  0, 15, 0,  1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0,  0, 15, 0,  0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0,  0, 15, 1,  0, 1));
    vecs.push_back(mk(1, 0, 0, 1, 0,  0, 15, 1,  0, 1));
    // Load clamp, then down-count from above a lowered limit.
    vecs.push_back(mk(0, 1, 0, 1, 0, 14, 10, 0, 10, 1));
    vecs.push_back(mk(0, 1, 0, 1, 0, 12, 15, 0, 12, 1));
    vecs.push_back(mk(1, 0, 0, 1, 0,  0, 10, 0, 10, 1));
    // Wrap with clr_ovf in the same cycle: set wins; clear afterwards.
    vecs.push_back(mk(0, 1, 1, 0, 1,  6,  7, 0,  6, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0,  0,  7, 0,  7, 0));
    vecs.push_back(mk(1, 0, 1, 0, 1,  0,  7, 1,  0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 1,  0,  7, 0,  0, 0));
    // Load and enable together at a boundary value: load wins, no tc.
    vecs.push_back(mk(0, 1, 1, 0, 0,  9,  9, 0,  9, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0,  5,  9, 0,  5, 0));
    // Saturate up, then immediate direction change.
    vecs.push_back(mk(0, 1, 1, 1, 0,  9,  9, 0,  9, 0));
    vecs.push_back(mk(1, 0, 1, 1, 0,  0,  9, 1,  9, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0,  0,  9, 0,  8, 1));
    vecs.push_back(mk(1, 0, 1, 0, 0,  0,  9, 0,  9, 1));
    // max_val = 0: stuck at 0, tc whenever counting.
    vecs.push_back(mk(0, 1, 1, 0, 1,  3,  0, 0,  0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0,  0,  0, 1,  0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 1,  0,  0, 1,  0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0,  0,  0, 0,  0, 1));
    // Down wrap from 0 to max, and up-count from above a lowered limit.
    vecs.push_back(mk(0, 1, 0, 0, 1,  0,  5, 0,  0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0,  0,  5, 1,  5, 1));
    vecs.push_back(mk(1, 0, 1, 0, 0,  0,  3, 1,  0, 1));
    vecs.push_back(mk(1, 0, 1, 0, 0,  0,  3, 0,  1, 1));
    vecs.push_back(mk(1, 0, 1, 0, 0,  0, 15, 0,  2, 1));

    // Reset with a count request pending: q=0 from reset with mode down would look like tc.
    rst = 1'b0; en = 1'b1; load = 1'b0; mode = 1'b0; sat = 1'b0;
    clr_ovf = 1'b0; din = 4'd0; max_val = 4'd9;
    @(negedge clk); @(negedge clk);
    #1;
    check("rst_q",   q,   0);
    check("rst_ovf", ovf, 0);
    check("rst_tc",  tc,  0);
    en = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      en = vecs[i].en; load = vecs[i].load; mode = vecs[i].mode; sat = vecs[i].sat;
      clr_ovf = vecs[i].clr; din = vecs[i].din; max_val = vecs[i].mx;
      #1;
      check($sformatf("v%0d_tc", i), tc, vecs[i].exp_tc);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_q", i),   q,   vecs[i].exp_q);
      check($sformatf("v%0d_ovf", i), ovf, vecs[i].exp_ovf);
    end

    // Asynchronous reset between edges while counting, with ovf set (q=2, ovf=1 from table).
    @(negedge clk);
    en = 1'b1; load = 1'b0; mode = 1'b1; sat = 1'b0; clr_ovf = 1'b0; max_val = 4'd15;
    @(posedge clk);
    #1;
    check("pre_rst_q", q, 3);
    #2;
    rst = 1'b0;
    mode = 1'b0;
    #1;
    check("async_rst_q",   q,   0);
    check("async_rst_ovf", ovf, 0);
    check("async_rst_tc",  tc,  0);

    // A load held across an edge while in reset must not land.
    @(negedge clk);
    en = 1'b0; load = 1'b1; din = 4'd5;
    @(posedge clk);
    #1;
    check("rst_abort_load_q", q, 0);

    // First load after release happens on the first rising edge.
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_load_q", q, 5);
    check("post_rst_ovf",    ovf, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_updown_mod_counter
